// File: rtl/cmd_arbiter.sv
// Two-requester command arbiter in front of cmd_proc: grants UART or tour,
// registers the command and routes the response back to the owner only.
// Optional busy timeout is enabled by defining CMD_ARB_TMO_EN.
module cmd_arbiter #(
  parameter logic TOUR_PRIO  = 1'b0,
  parameter int   TMO_CYCLES = 2**24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cmd_U,
  input  logic        cmd_rdy_U,
  output logic        clr_rdy_U,
  output logic        resp_vld_U,
  input  logic [15:0] cmd_T,
  input  logic        cmd_rdy_T,
  output logic        clr_rdy_T,
  output logic        resp_vld_T,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  input  logic [7:0]  resp_in,
  output logic [7:0]  resp,
  output logic        owner,
  output logic        busy,
  output logic        tmo_err
);

  typedef enum logic [1:0] {IDLE, GRANT, BUSY, RESP} state_t;

  state_t state, state_nxt;
  logic   last_owner;
  logic   clr_pend;
  logic   req_any;
  logic   grant_sel;
  logic   grant;
  logic   load_resp;
  logic   tmo_abort;
  logic   tmo_hit;

  // Tie-break: fixed tour priority, or hand the grant to whoever did not go last.
  always_comb begin
    req_any = cmd_rdy_U | cmd_rdy_T;
    if (cmd_rdy_U && cmd_rdy_T)
      grant_sel = TOUR_PRIO ? 1'b1 : ~last_owner;
    else
      grant_sel = cmd_rdy_T;
    grant = (state == IDLE) && req_any;
  end

`ifdef CMD_ARB_TMO_EN
  logic [23:0] tmo_cnt;
  logic        tmo_flag;

  assign tmo_hit = ((state == GRANT) || (state == BUSY)) &&
                   (tmo_cnt == 24'(TMO_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt  <= '0;
      tmo_flag <= 1'b0;
    end else begin
      if (grant)
        tmo_cnt <= '0;
      else if ((state == GRANT) || (state == BUSY))
        tmo_cnt <= tmo_cnt + 24'd1;
      tmo_flag <= tmo_abort;
    end
  end

  assign tmo_err = (state == RESP) && tmo_flag;
`else
  assign tmo_hit = 1'b0;
  assign tmo_err = 1'b0;
`endif

  // NOTE: every variable is given a default before the case so no latch is inferred.
  always_comb begin
    state_nxt = state;
    load_resp = 1'b0;
    tmo_abort = 1'b0;
    unique case (state)
      IDLE:  if (req_any) state_nxt = GRANT;
      GRANT: begin
        // A finished response outranks a timeout landing on the same cycle.
        if (clr_cmd_rdy && send_resp) begin
          state_nxt = RESP;
          load_resp = 1'b1;
        end else if (tmo_hit) begin
          state_nxt = RESP;
          load_resp = 1'b1;
          tmo_abort = 1'b1;
        end else if (clr_cmd_rdy) begin
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (send_resp) begin
          state_nxt = RESP;
          load_resp = 1'b1;
        end else if (tmo_hit) begin
          state_nxt = RESP;
          load_resp = 1'b1;
          tmo_abort = 1'b1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cmd        <= 16'h0000;
      resp       <= 8'h00;
      owner      <= 1'b0;
      last_owner <= 1'b0;
      clr_pend   <= 1'b0;
    end else begin
      state    <= state_nxt;
      clr_pend <= grant;
      if (grant) begin
        cmd        <= grant_sel ? cmd_T : cmd_U;
        owner      <= grant_sel;
        last_owner <= grant_sel;
      end
      if (load_resp)
        resp <= tmo_abort ? 8'hEE : resp_in;
    end
  end

  assign cmd_rdy    = (state == GRANT);
  assign busy       = (state != IDLE);
  assign clr_rdy_U  = clr_pend & ~owner;
  assign clr_rdy_T  = clr_pend & owner;
  assign resp_vld_U = (state == RESP) & ~owner;
  assign resp_vld_T = (state == RESP) & owner;

endmodule
